// File: rtl/riscv_pkg.sv
// riscv_pkg: core-wide widths, reset-vector default and the fetch FSM state encoding.
//   XLEN             address / PC width
//   ILEN             instruction word width
//   DEFAULT_RESET_PC first fetch address when the top does not override it
//   fetch_state_t    BOOT (one idle cycle), RUN (fetching), HALT (stopped until reset)
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instruction} pairs between fetch and decode.
//   clk, reset_n        clock, asynchronous active-low reset
//   push, push_pc/data  write one entry
//   pop                 retire the head entry
//   flush               empty the FIFO (wins over push/pop)
//   count               number of valid entries
//   head_pc, head_data  oldest entry, valid while count != 0
module fetch_fifo import riscv_pkg::*; #(
   parameter int DEPTH = 2
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [XLEN-1:0]        push_pc,
   input  logic [ILEN-1:0]        push_data,
   output logic [$clog2(DEPTH):0] count,
   output logic [XLEN-1:0]        head_pc,
   output logic [ILEN-1:0]        head_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [XLEN-1:0] pc_mem [DEPTH];
   logic [ILEN-1:0] data_mem [DEPTH];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   // Storage needs no reset; a full FIFO may push and pop together because the
   // head is read combinationally before the slot is overwritten at the edge.
   always_ff @(posedge clk)
      if (push && !flush) begin
         pc_mem[wr_ptr]   <= push_pc;
         data_mem[wr_ptr] <= push_data;
      end
   assign head_pc   = pc_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: RISC-V fetch stage; owns the PC, issues word reads to
// instruction memory, buffers returned words with their PCs for decode and
// squashes wrong-path instructions on a jump/branch redirect.
//   clk, reset_n               clock, asynchronous active-low reset
//   jb_enable, jb_target_pc    redirect request and target
//   imem_req, imem_addr        fetch request / word address
//   imem_gnt                   request accepted this cycle
//   imem_rvalid, imem_rdata    in-order read response
//   inst_valid, inst_pc,
//   inst_data, inst_ready      instruction handshake to decode
//   misalign_err               sticky: a redirect target was not word-aligned
module instruction_fetch import riscv_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 2
)(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            jb_enable,
   input  logic [XLEN-1:0] jb_target_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_pc,
   output logic [ILEN-1:0] inst_data,
   input  logic            inst_ready,
   output logic            misalign_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   fetch_state_t state;
   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0] outstanding, drop_cnt, fifo_count;
   logic [AW-1:0] pend_wr, pend_rd;
   logic [XLEN-1:0] pend_mem [FIFO_DEPTH];
   logic run, take_jb, take_halt, redirect, credit, grant, rsp, push, pop;

   assign run       = state == RUN;
   assign take_jb   = jb_enable && state != HALT;
   assign take_halt = take_jb && jb_target_pc[1:0] != 2'b00;
   assign redirect  = jb_enable && run;
   assign pop       = inst_valid && inst_ready;
   // An entry leaving for decode this cycle frees its slot before any response
   // to a request issued now can arrive, so it counts as credit; this is what
   // sustains one instruction per cycle with a two-entry buffer.
   assign credit     = outstanding + fifo_count - CW'(pop) < CW'(FIFO_DEPTH);
   assign imem_req   = run && !jb_enable && credit;
   assign imem_addr  = fetch_pc;
   assign grant      = imem_req && imem_gnt;
   // Responses with nothing outstanding belong to grants from before a reset.
   assign rsp        = imem_rvalid && outstanding != '0;
   assign push       = rsp && drop_cnt == '0 && !jb_enable;
   assign inst_valid = fifo_count != '0 && run && !jb_enable;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .flush     (redirect),
      .push_pc   (pend_mem[pend_rd]),
      .push_data (imem_rdata),
      .count     (fifo_count),
      .head_pc   (inst_pc),
      .head_data (inst_data)
   );

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= BOOT;
         fetch_pc     <= RESET_PC;
         outstanding  <= '0;
         drop_cnt     <= '0;
         misalign_err <= 1'b0;
         pend_wr      <= '0;
         pend_rd      <= '0;
      end else begin
         state        <= take_halt ? HALT : state == BOOT ? RUN : state;
         misalign_err <= misalign_err || take_halt;
         fetch_pc     <= take_jb ? jb_target_pc : grant ? fetch_pc + 32'd4 : fetch_pc;
         outstanding  <= outstanding + CW'(grant) - CW'(rsp);
         // Every request still in flight after a redirect is wrong-path; since
         // drop_cnt never exceeds outstanding this also covers stacked redirects.
         drop_cnt     <= redirect ? outstanding - CW'(rsp) : drop_cnt - CW'(rsp && drop_cnt != '0);
         pend_wr      <= grant ? pend_wr + AW'(1) : pend_wr;
         pend_rd      <= rsp ? pend_rd + AW'(1) : pend_rd;
      end

   // PCs of granted requests, paired in order with the responses.
   always_ff @(posedge clk)
      if (grant) pend_mem[pend_wr] <= fetch_pc;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench for instruction_fetch with a memory
// model and a program-order reference: decode must see consecutive PCs from the
// last accepted redirect target, each with the word stored at that address.
module tb_instruction_fetch;
   localparam int DEPTH = 2;
   logic clk = 1'b0, reset_n = 1'b0;
   logic jb_enable = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, inst_ready = 1'b0;
   logic [31:0] jb_target_pc = '0, imem_rdata = '0;
   logic imem_req, inst_valid, misalign_err;
   logic [31:0] imem_addr, inst_pc, inst_data;

   instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .jb_enable    (jb_enable),
      .jb_target_pc (jb_target_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .inst_valid   (inst_valid),
      .inst_pc      (inst_pc),
      .inst_data    (inst_data),
      .inst_ready   (inst_ready),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] pc; int due;} req_t;
   req_t mq[$];
   int cyc, last_due, n_cmp, n_bad, n_acc, n_grants, p_gnt, p_rdy, lat_lo, lat_hi;
   logic [31:0] exp_pc, exp_fetch, prev_acc;
   logic exp_err, saw_wrap, rel_pending;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      exp_pc = 32'h0;
      exp_fetch = 32'h0;
      exp_err = 1'b0;
      mq.delete();
      last_due = 0;
      cyc = 0;
   endtask

   // One clock cycle: drive inputs after the edge, judge the handshakes at the
   // falling edge (they take effect at the next rising edge).
   task automatic step(input logic jb, input logic [31:0] tgt, input logic junk);
      int lat, due;
      @(posedge clk);
      #1;
      if (rel_pending) begin
         reset_n = 1'b1;
         rel_pending = 1'b0;
      end
      imem_rvalid = junk || (mq.size() > 0 && mq[0].due <= cyc);
      imem_rdata  = junk ? $urandom : imem_rvalid ? mem_word(mq[0].pc) : 32'h0;
      imem_gnt    = $urandom_range(99) < p_gnt;
      inst_ready  = $urandom_range(99) < p_rdy;
      jb_enable   = jb;
      jb_target_pc = tgt;
      @(negedge clk);
      check("err", misalign_err, exp_err);
      if (cyc == 0) begin
         check("boot_req", imem_req, 0);
         check("boot_valid", inst_valid, 0);
      end
      if (exp_err || jb) begin
         check("blk_req", imem_req, 0);
         check("blk_valid", inst_valid, 0);
      end
      if (imem_rvalid && !junk) void'(mq.pop_front());
      if (imem_req) check("addr", imem_addr, exp_fetch);
      if (imem_req && imem_gnt) begin
         lat = $urandom_range(lat_hi, lat_lo);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mq.push_back('{exp_fetch, due});
         exp_fetch += 32'd4;
         n_grants++;
         check("credit", mq.size() <= DEPTH, 1);
      end
      if (inst_valid) begin
         check("pc", inst_pc, exp_pc);
         check("data", inst_data, mem_word(exp_pc));
      end
      if (inst_valid && inst_ready) begin
         if (exp_pc == 32'h0 && n_acc > 0 && prev_acc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
         prev_acc = exp_pc;
         exp_pc += 32'd4;
         n_acc++;
      end
      if (jb && !exp_err) begin
         if (tgt[1:0] != 2'b00) exp_err = 1'b1;
         else begin
            exp_pc = tgt;
            exp_fetch = tgt;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("rst_req", imem_req, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_err", misalign_err, 0);
      jb_enable = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      inst_ready = 1'b0;
      model_reset();
      rel_pending = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !inst_valid; i++) step(1'b0, 32'h0, 1'b0);
      check("valid_timeout", inst_valid, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a0;
      n_cmp = 0; n_bad = 0; n_acc = 0; n_grants = 0;
      saw_wrap = 1'b0; prev_acc = '0;
      p_gnt = 100; p_rdy = 100; lat_lo = 1; lat_hi = 1;
      model_reset();
      rel_pending = 1'b1;
      // zero-wait memory straight out of reset, stale rvalid in the BOOT cycle
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 32'h0, i == 0);
         if (i == 1) begin
            check("first_req", imem_req, 1);
            check("first_addr", imem_addr, 32'h0);
         end
         if (i >= 3) begin
            check("seq_valid", inst_valid, 1);
            check("seq_pc", inst_pc, 32'(4 * (i - 3)));
         end
      end
      // decode stalls for 10 cycles
      p_rdy = 0; n_grants = 0;
      repeat (10) step(1'b0, 32'h0, 1'b0);
      check("stall_grants", n_grants <= DEPTH, 1);
      check("stall_req", imem_req, 0);
      p_rdy = 100;
      repeat (6) step(1'b0, 32'h0, 1'b0);
      // latency 3, redirect with two requests in flight
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 20 && mq.size() != 2; i++) step(1'b0, 32'h0, 1'b0);
      check("inflight", mq.size(), 2);
      step(1'b1, 32'h100, 1'b0);
      wait_valid(20);
      check("redir_pc", inst_pc, 32'h100);
      // back-to-back redirects
      repeat (3) step(1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h200, 1'b0);
      step(1'b1, 32'h300, 1'b0);
      wait_valid(20);
      check("b2b_pc", inst_pc, 32'h300);
      // PC wrap-around
      lat_lo = 1; lat_hi = 1;
      step(1'b1, 32'hFFFF_FFF8, 1'b0);
      repeat (10) step(1'b0, 32'h0, 1'b0);
      check("wrap", saw_wrap, 1);
      // reset mid-stream restarts from the reset PC
      do_reset();
      wait_valid(20);
      check("rst_pc", inst_pc, 32'h0);
      repeat (4) step(1'b0, 32'h0, 1'b0);
      // misaligned target halts the stage
      step(1'b1, 32'h102, 1'b0);
      repeat (8) step(1'b0, 32'h0, 1'b0);
      check("halt_err", misalign_err, 1);
      // randomized rounds
      for (int r = 0; r < 4; r++) begin
         do_reset();
         p_gnt = $urandom_range(100, 30);
         p_rdy = $urandom_range(100, 30);
         lat_lo = 1;
         lat_hi = $urandom_range(4, 1);
         a0 = n_acc;
         for (int i = 0; i < 800; i++) begin
            logic jb;
            jb = $urandom_range(99) < 3;
            step(jb, $urandom & 32'h0000_0FFC, i == 0);
         end
         check("progress", (n_acc - a0) > 20, 1);
         if (r[0]) begin
            step(1'b1, ($urandom & 32'h0000_0FFC) | 32'h1, 1'b0);
            repeat (10) step(1'b0, 32'h0, 1'b0);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
